// File: rtl/dmem_rmw_ctrl_if.sv
// Request, response and SRAM bus bundle for the data-memory RMW controller.
// The master side is the MEM stage plus the SRAM; the slave side is the controller.
interface dmem_rmw_ctrl_if #(
   parameter int NB_ADDR   = 32,
   parameter int NB_WORD   = 32,
   parameter int NB_FUNCT3 = 3
);
   logic                 req_valid;
   logic                 req_wr;
   logic [NB_ADDR-1:0]   req_addr;
   logic [NB_WORD-1:0]   req_wr_data;
   logic [NB_FUNCT3-1:0] req_funct3;
   logic                 ready;
   logic                 done;
   logic                 fault;
   logic [NB_WORD-1:0]   rd_data;
   logic [NB_ADDR-3:0]   mem_addr;
   logic                 mem_rd_en;
   logic                 mem_wr_en;
   logic [NB_WORD-1:0]   mem_wr_data;
   logic [NB_WORD-1:0]   mem_rd_data;

   modport master (
      output req_valid, req_wr, req_addr, req_wr_data, req_funct3, mem_rd_data,
      input  ready, done, fault, rd_data, mem_addr, mem_rd_en, mem_wr_en, mem_wr_data
   );

   modport slave (
      input  req_valid, req_wr, req_addr, req_wr_data, req_funct3, mem_rd_data,
      output ready, done, fault, rd_data, mem_addr, mem_rd_en, mem_wr_en, mem_wr_data
   );
endinterface

// File: rtl/dmem_rmw_ctrl.sv
// Data-memory controller: byte/half/word loads and stores over a word-wide
// single-port SRAM with 1-cycle read latency. Sub-word stores use
// read-modify-write; loads are lane-extracted and sign/zero-extended.
module dmem_rmw_ctrl #(
   parameter int NB_ADDR   = 32,
   parameter int NB_WORD   = 32,
   parameter int NB_FUNCT3 = 3
) (
   input logic               i_clock,
   input logic               i_reset,
   dmem_rmw_ctrl_if.slave    bus
);
   localparam int N_LANES = NB_WORD / 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_RESP,
      ST_RMW,
      ST_WRITE,
      ST_FAULT
   } state_t;

   state_t               state_reg;
   logic                 wr_reg;
   logic [NB_ADDR-1:0]   addr_reg;
   logic [NB_WORD-1:0]   req_data_reg;
   logic [NB_FUNCT3-1:0] funct3_reg;
   logic                 ready_reg;
   logic                 done_reg;
   logic                 fault_reg;
   logic [NB_WORD-1:0]   rd_data_reg;
   logic [NB_ADDR-3:0]   mem_addr_reg;
   logic                 mem_rd_en_reg;
   logic                 mem_wr_en_reg;
   logic [NB_WORD-1:0]   mem_wr_data_reg;

   logic                 req_fault;
   logic                 req_illegal;
   logic                 req_misaligned;
   logic [NB_WORD-1:0]   merged_word;
   logic [NB_WORD-1:0]   load_value;
   logic [7:0]           rd_bytes [N_LANES];
   logic [7:0]           byte_pick;
   logic [15:0]          half_pick;
   logic                 store_is_byte;

   // Fault decode on the live request; only meaningful in IDLE when accepting.
   always_comb begin
      req_illegal    = 1'b0;
      req_misaligned = 1'b0;
      if (bus.req_wr) begin
         req_illegal = (bus.req_funct3 >= 3'b011);
      end else begin
         req_illegal = (bus.req_funct3 == 3'b011) || (bus.req_funct3 == 3'b110) ||
                       (bus.req_funct3 == 3'b111);
      end
      if (bus.req_funct3[1:0] == 2'b01) begin
         req_misaligned = bus.req_addr[0];
      end else if (bus.req_funct3[1:0] == 2'b10) begin
         req_misaligned = (bus.req_addr[1:0] != 2'b00);
      end
      req_fault = req_illegal || req_misaligned;
   end

   assign store_is_byte = (funct3_reg[1:0] == 2'b00);

   // Per-lane merge for RMW and lane split for loads, both straight off the SRAM read word.
   generate
      for (genvar gi = 0; gi < N_LANES; gi++) begin : g_lane
         logic       lane_hit;
         logic [7:0] lane_src;
         assign lane_hit = store_is_byte ? (addr_reg[1:0] == 2'(gi))
                                         : (addr_reg[1] == 1'(gi / 2));
         assign lane_src = store_is_byte ? req_data_reg[7:0]
                                         : req_data_reg[8*(gi%2) +: 8];
         assign merged_word[8*gi +: 8] = lane_hit ? lane_src : bus.mem_rd_data[8*gi +: 8];
         assign rd_bytes[gi] = bus.mem_rd_data[8*gi +: 8];
      end
   endgenerate

   // Lane extraction and extension of the SRAM read word for the pending load.
   always_comb begin
      byte_pick = rd_bytes[addr_reg[1:0]];
      half_pick = addr_reg[1] ? bus.mem_rd_data[31:16] : bus.mem_rd_data[15:0];
      case (funct3_reg)
         3'b000:  load_value = {{(NB_WORD-8){byte_pick[7]}}, byte_pick};
         3'b001:  load_value = {{(NB_WORD-16){half_pick[15]}}, half_pick};
         3'b100:  load_value = {{(NB_WORD-8){1'b0}}, byte_pick};
         3'b101:  load_value = {{(NB_WORD-16){1'b0}}, half_pick};
         default: load_value = bus.mem_rd_data;
      endcase
   end

   // Controller FSM with registered handshake and SRAM strobes.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_reg       <= ST_IDLE;
         wr_reg          <= 1'b0;
         addr_reg        <= '0;
         req_data_reg    <= '0;
         funct3_reg      <= '0;
         ready_reg       <= 1'b1;
         done_reg        <= 1'b0;
         fault_reg       <= 1'b0;
         rd_data_reg     <= '0;
         mem_addr_reg    <= '0;
         mem_rd_en_reg   <= 1'b0;
         mem_wr_en_reg   <= 1'b0;
         mem_wr_data_reg <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (bus.req_valid) begin
                  wr_reg       <= bus.req_wr;
                  addr_reg     <= bus.req_addr;
                  req_data_reg <= bus.req_wr_data;
                  funct3_reg   <= bus.req_funct3;
                  mem_addr_reg <= bus.req_addr[NB_ADDR-1:2];
                  ready_reg    <= 1'b0;
                  if (req_fault) begin
                     state_reg <= ST_FAULT;
                     done_reg  <= 1'b1;
                     fault_reg <= 1'b1;
                  end else if (bus.req_wr && (bus.req_funct3[1:0] == 2'b10)) begin
                     state_reg       <= ST_WRITE;
                     mem_wr_en_reg   <= 1'b1;
                     mem_wr_data_reg <= bus.req_wr_data;
                     done_reg        <= 1'b1;
                  end else begin
                     state_reg     <= ST_READ;
                     mem_rd_en_reg <= 1'b1;
                  end
               end
            end
            ST_READ: begin
               mem_rd_en_reg <= 1'b0;
               done_reg      <= 1'b1;
               if (wr_reg) begin
                  state_reg     <= ST_RMW;
                  mem_wr_en_reg <= 1'b1;
               end else begin
                  state_reg <= ST_RESP;
               end
            end
            ST_RESP: begin
               rd_data_reg <= load_value;
               done_reg    <= 1'b0;
               ready_reg   <= 1'b1;
               state_reg   <= ST_IDLE;
            end
            ST_RMW: begin
               mem_wr_data_reg <= merged_word;
               mem_wr_en_reg   <= 1'b0;
               done_reg        <= 1'b0;
               ready_reg       <= 1'b1;
               state_reg       <= ST_IDLE;
            end
            default: begin
               // WRITE and FAULT both finish in one cycle.
               mem_wr_en_reg <= 1'b0;
               done_reg      <= 1'b0;
               fault_reg     <= 1'b0;
               ready_reg     <= 1'b1;
               state_reg     <= ST_IDLE;
            end
         endcase
      end
   end

   // Strobes and completion are masked by reset so an interrupted request never writes or completes.
   assign bus.ready       = ready_reg;
   assign bus.done        = done_reg & ~i_reset;
   assign bus.fault       = fault_reg & ~i_reset;
   assign bus.mem_rd_en   = mem_rd_en_reg & ~i_reset;
   assign bus.mem_wr_en   = mem_wr_en_reg & ~i_reset;
   assign bus.mem_addr    = mem_addr_reg;
   // Read data and merged word only exist in the cycle after the SRAM read, so they bypass the registers there.
   assign bus.rd_data     = ((state_reg == ST_RESP) && !i_reset) ? load_value : rd_data_reg;
   assign bus.mem_wr_data = (state_reg == ST_RMW) ? merged_word : mem_wr_data_reg;
endmodule

// File: tb/tb_dmem_rmw_ctrl.sv
// Directed self-checking bench for dmem_rmw_ctrl with a small behavioural SRAM.
module tb_dmem_rmw_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

   logic        pl_en = 1'b0;
   logic [6:0]  pl_idx = '0;
   logic [31:0] pl_data = '0;
   logic [31:0] mem [128];
   logic [31:0] mem_q = '0;

   dmem_rmw_ctrl_if bus ();

   dmem_rmw_ctrl dut (
      .i_clock (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // SRAM model: 1-cycle registered read, full-word write, plus a bench preload port.
   always @(posedge clk) begin
      if (pl_en) begin
         mem[pl_idx] <= pl_data;
      end else if (bus.mem_wr_en) begin
         mem[bus.mem_addr[6:0]] <= bus.mem_wr_data;
      end
      if (bus.mem_rd_en) begin
         mem_q <= mem[bus.mem_addr[6:0]];
      end
   end
   assign bus.mem_rd_data = mem_q;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic preload(input logic [6:0] idx, input logic [31:0] data);
      pl_en   = 1'b1;
      pl_idx  = idx;
      pl_data = data;
      tick();
      pl_en   = 1'b0;
   endtask

   task automatic drive_req(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                            input logic [2:0] f3);
      bus.req_valid   = 1'b1;
      bus.req_wr      = wr;
      bus.req_addr    = addr;
      bus.req_wr_data = data;
      bus.req_funct3  = f3;
   endtask

   task automatic do_load(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] exp);
      check({tag, "_c0_ready"}, 32'(bus.ready), 32'd1);
      drive_req(1'b0, addr, 32'h0, f3);
      tick();
      bus.req_valid = 1'b0;
      check({tag, "_c1_rd_en"}, 32'(bus.mem_rd_en), 32'd1);
      check({tag, "_c1_done"}, 32'(bus.done), 32'd0);
      tick();
      check({tag, "_c2_done"}, 32'(bus.done), 32'd1);
      check({tag, "_c2_fault"}, 32'(bus.fault), 32'd0);
      check({tag, "_c2_rd_data"}, bus.rd_data, exp);
      tick();
      check({tag, "_c3_ready"}, 32'(bus.ready), 32'd1);
      check({tag, "_c3_rd_hold"}, bus.rd_data, exp);
      $display("load %s addr=%h f3=%b rd_data=%h", tag, addr, f3, bus.rd_data);
   endtask

   task automatic do_fault(input string tag, input logic wr, input logic [31:0] addr,
                           input logic [2:0] f3, input logic [31:0] exp_rd);
      drive_req(wr, addr, 32'h12345678, f3);
      tick();
      bus.req_valid = 1'b0;
      check({tag, "_done"}, 32'(bus.done), 32'd1);
      check({tag, "_fault"}, 32'(bus.fault), 32'd1);
      check({tag, "_rd_en"}, 32'(bus.mem_rd_en), 32'd0);
      check({tag, "_wr_en"}, 32'(bus.mem_wr_en), 32'd0);
      check({tag, "_rd_keep"}, bus.rd_data, exp_rd);
      tick();
      check({tag, "_c2_done"}, 32'(bus.done), 32'd0);
      check({tag, "_c2_ready"}, 32'(bus.ready), 32'd1);
      $display("fault %s wr=%0d addr=%h f3=%b", tag, wr, addr, f3);
   endtask

   initial begin
      bus.req_valid   = 1'b0;
      bus.req_wr      = 1'b0;
      bus.req_addr    = '0;
      bus.req_wr_data = '0;
      bus.req_funct3  = '0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      check("rst_ready", 32'(bus.ready), 32'd1);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_fault", 32'(bus.fault), 32'd0);
      check("rst_rd_en", 32'(bus.mem_rd_en), 32'd0);
      check("rst_wr_en", 32'(bus.mem_wr_en), 32'd0);
      check("rst_rd_data", bus.rd_data, 32'h0);
      check("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
      check("rst_wr_data", bus.mem_wr_data, 32'h0);
      $display("reset released");

      // SW 0x100 <- 0xDEADBEEF, done in C1
      drive_req(1'b1, 32'h100, 32'hDEADBEEF, 3'b010);
      tick();
      bus.req_valid = 1'b0;
      check("sw_wr_en", 32'(bus.mem_wr_en), 32'd1);
      check("sw_rd_en", 32'(bus.mem_rd_en), 32'd0);
      check("sw_mem_addr", 32'(bus.mem_addr), 32'h40);
      check("sw_wr_data", bus.mem_wr_data, 32'hDEADBEEF);
      check("sw_done", 32'(bus.done), 32'd1);
      check("sw_ready_busy", 32'(bus.ready), 32'd0);
      tick();
      check("sw_c2_wr_en", 32'(bus.mem_wr_en), 32'd0);
      check("sw_c2_ready", 32'(bus.ready), 32'd1);
      check("sw_mem_word", mem[64], 32'hDEADBEEF);
      $display("store SW addr=00000100 data=deadbeef");

      // SB 0x102 <- 0xAA over 0x11223344
      preload(7'd64, 32'h11223344);
      drive_req(1'b1, 32'h102, 32'h000000AA, 3'b000);
      tick();
      bus.req_valid = 1'b0;
      check("sb_c1_rd_en", 32'(bus.mem_rd_en), 32'd1);
      check("sb_c1_done", 32'(bus.done), 32'd0);
      check("sb_c1_mem_addr", 32'(bus.mem_addr), 32'h40);
      tick();
      check("sb_c2_wr_en", 32'(bus.mem_wr_en), 32'd1);
      check("sb_c2_wr_data", bus.mem_wr_data, 32'h11AA3344);
      check("sb_c2_done", 32'(bus.done), 32'd1);
      tick();
      check("sb_c3_ready", 32'(bus.ready), 32'd1);
      check("sb_mem_word", mem[64], 32'h11AA3344);
      $display("store SB addr=00000102 merged=11aa3344");

      // SH 0x102 <- 0xBEEF over 0x11AA3344
      drive_req(1'b1, 32'h102, 32'h0000BEEF, 3'b001);
      tick();
      bus.req_valid = 1'b0;
      tick();
      check("sh_c2_wr_data", bus.mem_wr_data, 32'hBEEF3344);
      tick();
      $display("store SH addr=00000102 merged=beef3344");

      // Loads over 0x80FF7F01
      preload(7'd64, 32'h80FF7F01);
      do_load("lb_103", 32'h103, 3'b000, 32'hFFFFFF80);
      do_load("lbu_103", 32'h103, 3'b100, 32'h00000080);
      do_load("lh_100", 32'h100, 3'b001, 32'h00007F01);
      do_load("lh_102", 32'h102, 3'b001, 32'hFFFF80FF);
      do_load("lhu_102", 32'h102, 3'b101, 32'h000080FF);
      do_load("lw_100", 32'h100, 3'b010, 32'h80FF7F01);

      // Faults: misaligned and illegal funct3
      do_fault("lw_102", 1'b0, 32'h102, 3'b010, 32'h80FF7F01);
      do_fault("sh_101", 1'b1, 32'h101, 3'b001, 32'h80FF7F01);
      do_fault("ld_f3_011", 1'b0, 32'h100, 3'b011, 32'h80FF7F01);
      do_fault("st_f3_100", 1'b1, 32'h100, 3'b100, 32'h80FF7F01);
      check("fault_no_write", mem[64], 32'h80FF7F01);

      // Reset in the RMW cycle: no write, no done
      preload(7'd66, 32'hCAFEF00D);
      drive_req(1'b1, 32'h108, 32'h00000077, 3'b000);
      tick();
      bus.req_valid = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      check("rmwrst_wr_en", 32'(bus.mem_wr_en), 32'd0);
      check("rmwrst_done", 32'(bus.done), 32'd0);
      tick();
      rst = 1'b0;
      check("rmwrst_ready", 32'(bus.ready), 32'd1);
      check("rmwrst_done_after", 32'(bus.done), 32'd0);
      check("rmwrst_mem", mem[66], 32'hCAFEF00D);
      $display("reset mid-RMW addr=00000108");

      // Back-to-back SB then LW with valid held high
      preload(7'd65, 32'h01020304);
      drive_req(1'b1, 32'h105, 32'h00000055, 3'b000);
      tick();
      drive_req(1'b0, 32'h104, 32'h0, 3'b010);
      check("b2b_c1_ready", 32'(bus.ready), 32'd0);
      tick();
      check("b2b_c2_done", 32'(bus.done), 32'd1);
      check("b2b_c2_wr_data", bus.mem_wr_data, 32'h01025504);
      check("b2b_c2_ready", 32'(bus.ready), 32'd0);
      tick();
      check("b2b_c3_ready", 32'(bus.ready), 32'd1);
      check("b2b_c3_done", 32'(bus.done), 32'd0);
      tick();
      bus.req_valid = 1'b0;
      check("b2b_c4_rd_en", 32'(bus.mem_rd_en), 32'd1);
      check("b2b_c4_wr_en", 32'(bus.mem_wr_en), 32'd0);
      tick();
      check("b2b_c5_done", 32'(bus.done), 32'd1);
      check("b2b_c5_rd_data", bus.rd_data, 32'h01025504);
      tick();
      check("b2b_c6_done", 32'(bus.done), 32'd0);
      tick();
      check("b2b_c7_rd_en", 32'(bus.mem_rd_en), 32'd0);
      check("b2b_c7_done", 32'(bus.done), 32'd0);
      $display("back-to-back SB 00000105 then LW 00000104 rd_data=%h", bus.rd_data);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
